// File: rtl/scan_fifo_pkg.sv
// Shared helpers for the parametrised scan FIFO: address sizing, scan chain
// length and the bit position of each field inside the scan chain.
package scan_fifo_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_SWAP
    } fifo_op_t;

    localparam int CHAIN_OFF_COUNT = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Chain order, MSB first: dataout, underflow, overflow, rd_p, wr_p, count.
    function automatic int chain_len(input int dataW, input int depth);
        return dataW + 2 + 3 * clog2(depth) + 1;
    endfunction

    function automatic int chain_off_wr(input int depth);
        return CHAIN_OFF_COUNT + clog2(depth) + 1;
    endfunction

    function automatic int chain_off_rd(input int depth);
        return chain_off_wr(depth) + clog2(depth);
    endfunction

    function automatic int chain_off_ovf(input int depth);
        return chain_off_rd(depth) + clog2(depth);
    endfunction

    function automatic int chain_off_unf(input int depth);
        return chain_off_ovf(depth) + 1;
    endfunction

    function automatic int chain_off_data(input int depth);
        return chain_off_unf(depth) + 1;
    endfunction

endpackage

// File: rtl/scan_fifo_mem.sv
// Storage array for the scan FIFO: one write port, one combinational read port.
// The array is deliberately outside both reset and the scan chain.
module scan_fifo_mem
    import scan_fifo_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [AW-1:0]     i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [AW-1:0]     i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/scan_fifo_param.sv
// Parametrised synchronous FIFO with sticky error flags and a shift-mode scan
// chain covering dataout, error flags, both pointers and the occupancy count.
module scan_fifo_param
    import scan_fifo_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_en,
    input  logic [DATA_W-1:0] datain,
    input  logic              r_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dataout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              TM,
    input  logic              SE,
    input  logic              SI,
    output logic              SO
);

    localparam int L        = chain_len(DATA_W, DEPTH);
    localparam int OFF_WR   = chain_off_wr(DEPTH);
    localparam int OFF_RD   = chain_off_rd(DEPTH);
    localparam int OFF_OVF  = chain_off_ovf(DEPTH);
    localparam int OFF_UNF  = chain_off_unf(DEPTH);
    localparam int OFF_DATA = chain_off_data(DEPTH);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT   = (AW + 1)'(AE_LEVEL);

    logic [DATA_W-1:0] r_dataout;
    logic              r_overflow;
    logic              r_underflow;
    logic [AW-1:0]     r_rdPtr;
    logic [AW-1:0]     r_wrPtr;
    logic [AW:0]       r_count;

    logic              w_scanShift;
    logic              w_empty;
    logic              w_full;
    logic              w_wrAccept;
    logic              w_rdAccept;
    logic [DATA_W-1:0] w_memRdData;
    logic [L-1:0]      w_chain;
    logic [L-1:0]      w_shifted;
    fifo_op_t          w_op;

    assign w_scanShift = TM & SE;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);

    // A full FIFO still drains and an empty one still fills; only the
    // impossible half of a simultaneous request is dropped.
    assign w_wrAccept = w_en & ~w_full & ~w_scanShift;
    assign w_rdAccept = r_en & ~w_empty & ~w_scanShift;

    assign w_chain   = {r_dataout, r_underflow, r_overflow, r_rdPtr, r_wrPtr, r_count};
    assign w_shifted = {w_chain[L-2:0], SI};

    always_comb begin
        w_op = OP_HOLD;
        case ({w_wrAccept, w_rdAccept})
            2'b10:   w_op = OP_PUSH;
            2'b01:   w_op = OP_POP;
            2'b11:   w_op = OP_SWAP;
            default: w_op = OP_HOLD;
        endcase
    end

    scan_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_wrAccept),
        .i_wrAddr (r_wrPtr),
        .i_wrData (datain),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_memRdData)
    );

    // Scan shift takes priority over every functional update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dataout   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
        end else if (w_scanShift) begin
            r_dataout   <= w_shifted[L-1:OFF_DATA];
            r_underflow <= w_shifted[OFF_UNF];
            r_overflow  <= w_shifted[OFF_OVF];
            r_rdPtr     <= w_shifted[OFF_RD +: AW];
            r_wrPtr     <= w_shifted[OFF_WR +: AW];
            r_count     <= w_shifted[CHAIN_OFF_COUNT +: AW + 1];
        end else begin
            if (w_rdAccept) begin
                r_dataout <= w_memRdData;
                r_rdPtr   <= r_rdPtr + 1'b1;
            end
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            case (w_op)
                OP_PUSH: r_count <= r_count + 1'b1;
                OP_POP:  r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Setting an error wins over clearing it in the same cycle.
            if (w_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (r_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dataout      = r_dataout;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign SO           = w_chain[L-1];

endmodule

// File: tb/tb_scan_fifo_param.sv
// Directed bench for scan_fifo_param at default parameters (10 bits x 16 deep),
// covering fill/drain, streaming, error flags, scan unload/reload and async reset.
module tb_scan_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       w_en;
    logic [9:0] datain;
    logic       r_en;
    logic       clr_err;
    logic [9:0] dataout;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       TM;
    logic       SE;
    logic       SI;
    logic       SO;

    int errors = 0;
    int checks = 0;

    scan_fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .w_en         (w_en),
        .datain       (datain),
        .r_en         (r_en),
        .clr_err      (clr_err),
        .dataout      (dataout),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .TM           (TM),
        .SE           (SE),
        .SI           (SI),
        .SO           (SO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; datain = '0;
        TM = 1'b0; SE = 1'b0; SI = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; datain = '0;
        TM = 1'b0; SE = 1'b0; SI = 1'b0;
        reset = 1'b1;
        #12;
        checks++; if (dataout !== 10'd0) begin errors++; $display("[TB] FAIL reset_dataout: got %0d expected 0", dataout); end
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_empty_full: got %b%b expected 10", empty, full); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost: got %b%b expected 10", almost_empty, almost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_errflags: got %b%b expected 00", overflow, underflow); end
        checks++; if (SO !== 1'b0) begin errors++; $display("[TB] FAIL reset_SO: got %b expected 0", SO); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; datain = 10'(i);
            step();
            checks++; if (count !== 5'(i)) begin errors++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, i); end
            checks++; if (almost_full !== (i >= 14)) begin errors++; $display("[TB] FAIL fill_almost_full at %0d: got %b", i, almost_full); end
            checks++; if (full !== (i == 16)) begin errors++; $display("[TB] FAIL fill_full at %0d: got %b", i, full); end
            checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty at %0d: got %b expected 0", i, empty); end
        end
        datain = 10'd17;
        step();
        w_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_17th: got %b expected 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("[TB] FAIL count_after_17th: got %0d expected 16", count); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            r_en = 1'b1;
            step();
            checks++; if (dataout !== 10'(i)) begin errors++; $display("[TB] FAIL drain_data: got %0d expected %0d", dataout, i); end
            checks++; if (count !== 5'(16 - i)) begin errors++; $display("[TB] FAIL drain_count: got %0d expected %0d", count, 16 - i); end
            checks++; if (almost_empty !== (16 - i <= 2)) begin errors++; $display("[TB] FAIL drain_almost_empty at %0d: got %b", 16 - i, almost_empty); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
        step();
        r_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_extra: got %b expected 1", underflow); end
        checks++; if (dataout !== 10'd16) begin errors++; $display("[TB] FAIL dataout_hold: got %0d expected 16", dataout); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_err_both: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            w_en = 1'b1; datain = 10'(100 + k);
            step();
        end
        checks++; if (count !== 5'd8) begin errors++; $display("[TB] FAIL b2b_prefill: got %0d expected 8", count); end
        for (int j = 0; j < 20; j++) begin
            w_en = 1'b1; r_en = 1'b1; datain = 10'(200 + j);
            step();
            checks++; if (dataout !== ((j < 8) ? 10'(100 + j) : 10'(192 + j))) begin
                errors++; $display("[TB] FAIL b2b_data cycle %0d: got %0d", j, dataout);
            end
            checks++; if (count !== 5'd8) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 8", count); end
        end
        w_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r_en = 1'b1;
            step();
            checks++; if (dataout !== 10'(212 + k)) begin errors++; $display("[TB] FAIL b2b_drain: got %0d expected %0d", dataout, 212 + k); end
        end
        r_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 1", empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; datain = 10'(300 + i);
            step();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL sim_full: got %b expected 1", full); end
        datain = 10'd999; r_en = 1'b1;
        step();
        w_en = 1'b0; r_en = 1'b0;
        checks++; if (count !== 5'd15) begin errors++; $display("[TB] FAIL sim_full_count: got %0d expected 15", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL sim_full_overflow: got %b expected 1", overflow); end
        checks++; if (dataout !== 10'd300) begin errors++; $display("[TB] FAIL sim_full_data: got %0d expected 300", dataout); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sim_clr_overflow: got %b expected 0", overflow); end
        checks++; if (count !== 5'd15) begin errors++; $display("[TB] FAIL sim_clr_count: got %0d expected 15", count); end
        for (int i = 1; i < 16; i++) begin
            r_en = 1'b1;
            step();
            checks++; if (dataout !== 10'(300 + i)) begin errors++; $display("[TB] FAIL sim_drain: got %0d expected %0d", dataout, 300 + i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL sim_drain_empty: got %b expected 1", empty); end
        w_en = 1'b1; r_en = 1'b1; datain = 10'd42;
        step();
        w_en = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL sim_empty_count: got %0d expected 1", count); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL sim_empty_underflow: got %b expected 1", underflow); end
        checks++; if (dataout !== 10'd315) begin errors++; $display("[TB] FAIL sim_empty_hold: got %0d expected 315", dataout); end
        step();
        r_en = 1'b0;
        checks++; if (dataout !== 10'd42) begin errors++; $display("[TB] FAIL sim_empty_read: got %0d expected 42", dataout); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_scan();
        logic [24:0] expChain;
        logic [24:0] loadVec;
        expChain = {10'h155, 1'b0, 1'b0, 4'd1, 4'd3, 5'd2};
        loadVec  = {10'h000, 1'b0, 1'b0, 4'd1, 4'd3, 5'd2};
        do_reset();
        w_en = 1'b1; datain = 10'h155; step();
        datain = 10'h0AA; step();
        SE = 1'b1; datain = 10'h3C3; step();
        SE = 1'b0; w_en = 1'b0;
        checks++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL se_ignored_without_tm: got %0d expected 3", count); end
        r_en = 1'b1; step(); r_en = 1'b0;
        checks++; if (dataout !== 10'h155) begin errors++; $display("[TB] FAIL scan_preread: got %h expected 155", dataout); end
        TM = 1'b1; SE = 1'b1; SI = 1'b0;
        w_en = 1'b1; r_en = 1'b1; datain = 10'h2FF;
        for (int k = 0; k < 25; k++) begin
            checks++; if (SO !== expChain[24 - k]) begin errors++; $display("[TB] FAIL scan_unload bit %0d: got %b expected %b", 24 - k, SO, expChain[24 - k]); end
            step();
        end
        checks++; if (count !== 5'd0 || dataout !== 10'd0) begin errors++; $display("[TB] FAIL scan_flushed: got count %0d data %h expected 0 0", count, dataout); end
        for (int k = 0; k < 25; k++) begin
            SI = loadVec[24 - k];
            step();
        end
        SI = 1'b0;
        checks++; if (count !== 5'd2) begin errors++; $display("[TB] FAIL scan_reload_count: got %0d expected 2", count); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL scan_reload_flags: got %b%b expected 00", overflow, underflow); end
        TM = 1'b0; SE = 1'b0; w_en = 1'b0; r_en = 1'b1;
        step();
        checks++; if (dataout !== 10'h0AA) begin errors++; $display("[TB] FAIL scan_mem_word1: got %h expected 0aa", dataout); end
        step();
        r_en = 1'b0;
        checks++; if (dataout !== 10'h3C3) begin errors++; $display("[TB] FAIL scan_mem_word2: got %h expected 3c3", dataout); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL scan_mem_empty: got %b expected 1", empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        w_en = 1'b1; datain = 10'h3FF; step();
        w_en = 1'b0; r_en = 1'b1; step(); r_en = 1'b0;
        checks++; if (SO !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_SO: got %b expected 1", SO); end
        TM = 1'b1; SE = 1'b1; SI = 1'b1;
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dataout !== 10'd0 || SO !== 1'b0) begin errors++; $display("[TB] FAIL midscan_reset_data: got %h/%b expected 0/0", dataout, SO); end
        checks++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL midscan_reset_count: got %0d e%b ae%b expected 0 1 1", count, empty, almost_empty); end
        TM = 1'b0; SE = 1'b0; SI = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            w_en = 1'b1; datain = 10'(i);
            step();
        end
        r_en = 1'b1; datain = 10'd6;
        step();
        r_en = 1'b0;
        checks++; if (dataout !== 10'd1 || count !== 5'd5) begin errors++; $display("[TB] FAIL burst_pre_reset: got %0d/%0d expected 1/5", dataout, count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dataout !== 10'd0 || count !== 5'd0) begin errors++; $display("[TB] FAIL burst_reset: got %0d/%0d expected 0/0", dataout, count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("[TB] FAIL burst_reset_flags: got %b%b%b expected 100", empty, full, almost_full); end
        w_en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simultaneous();
        test_scan();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_fifo_param.md
# scan_fifo_param

Parametrised synchronous FIFO with a full-length scan chain over all control and output state. It succeeds the fixed 10x16 scan FIFO and adds:
- configurable width and depth
- a correct full condition at `DEPTH`
- almost-full/almost-empty flags
- sticky overflow/underflow error flags
- a proper shift-mode scan chain that replaces address scrambling

It sits in the datapath buffering layer and is the DFT-visible FIFO primitive for new designs.

## Interface
- `DATA_W`, 10, data word width (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥4
- `AF_LEVEL`, `DEPTH-2`, `almost_full` asserts when `count >= AF_LEVEL`
- `AE_LEVEL`, 2, `almost_empty` asserts when `count <= AE_LEVEL`
- `clk` input 1 clock; all state updates on rising edge
- `reset` input 1 asynchronous, active-high
- `w_en` input 1 write request
- `datain` input `DATA_W` write data
- `r_en` input 1 read request
- `clr_err` input 1 synchronous clear of `overflow`/`underflow`
- `dataout` output `DATA_W` registered read data
- `empty`, `full`, `almost_empty`, `almost_full` output 1 status, combinational from `count`
- `count` output `AW+1` occupancy, where `AW = log2(DEPTH)`
- `overflow`, `underflow` output 1 sticky error flags
- `TM` input 1 test mode
- `SE` input 1 scan shift enable; effective only when `TM=1`
- `SI` input 1 scan in
- `SO` output 1 scan out

## Operation
- Write is accepted when `w_en && !full`: `mem[wr_p] <= datain`, `wr_p++`.
- Read is accepted when `r_en && !empty`: `dataout <= mem[rd_p]`, `rd_p++`. Otherwise `dataout` holds.
- Count update:
  - both accepted: `count` unchanged
  - write only: `+1`
  - read only: `-1`
- Simultaneous `w_en`/`r_en` while full: the read is accepted, the write is rejected, and `overflow` sets.
- Simultaneous `w_en`/`r_en` while empty: the write is accepted, the read is rejected, and `underflow` sets. There is no fall-through.
- Pointers are `AW` bits and wrap naturally from `DEPTH-1` to 0. `count` is `AW+1` bits and never exceeds `DEPTH`.
- Status flags:
  - `empty = (count==0)`
  - `full = (count==DEPTH)`
- `overflow` sets on `w_en && full`. `underflow` sets on `r_en && empty`. Both stay set until `reset` or `clr_err`. If `clr_err` and a set condition occur in the same cycle, set wins.
- Scan (`TM && SE`):
  - Functional updates are suppressed: no memory write, no pointer/count/flag updates.
  - The chain shifts one bit per clock. Chain vector, MSB first: `{dataout, underflow, overflow, rd_p, wr_p, count}`.
  - Shift: `chain <= {chain[L-2:0], SI}`. `SO = chain[L-1]`, i.e. `dataout[DATA_W-1]`.
  - `L = DATA_W + 2 + 2*AW + AW + 1` (25 at defaults).
- `TM && !SE`: normal functional operation (capture cycle). `SO` still reflects `chain[L-1]`.
- `TM=0`: `SE` is ignored.
- Memory array is neither reset nor scanned.

## Timing
- Reset values: `dataout=0`, `wr_p=0`, `rd_p=0`, `count=0`, `overflow=0`, `underflow=0`. Hence `empty=1`, `full=0`, `almost_empty=1`, `almost_full=0`, `SO=0`.
- Reset is asynchronous. It aborts any operation mid-stream, including a scan shift. Contents of the memory array are then undefined to the user.
- Read latency: 1 clock from the accepted `r_en` edge to `dataout` valid.
- Write-to-read: data written at edge N is readable by a read accepted at edge N+1. `empty` deasserts after edge N.
- Flags and `count` change only on clock edges, or asynchronously with `reset`.
- Full scan unload/load takes `L` clocks with `SE=1`.

## Structure
- Package `scan_fifo_pkg`:
  - `clog2` function
  - chain-length function `chain_len(DATA_W, DEPTH)`
  - chain field offset constants
- Sub-module `scan_fifo_mem`: `DEPTH x DATA_W` single-write, single-read-address register array. Write is gated by an external write enable; combinational read.
- Top level holds the pointers, count, flags, error logic and the scan chain mux.

## Test plan
- Reset then write 16 words 1..16 (defaults): `count=16`, `full=1`, `almost_full` first seen at `count=14`. A 17th write sets `overflow=1` and leaves `count=16`.
- Read 16 words: `dataout` = 1..16 in order, each 1 cycle after its `r_en`. `empty=1` after the last read. An extra read sets `underflow` and leaves `dataout=16`.
- Fill to 8, then 20 cycles with `w_en=r_en=1`: `count` stays 8, pointers wrap past 15, and data order is preserved.
- Simultaneous read/write when full: read accepted, `count` goes 16→15, `overflow=1`. Assert `clr_err` on the next cycle: `overflow=0`.
- Scan: after 3 writes and 1 read of `0x155`, set `TM=SE=1` and shift 25 clocks with `SI=0`. `SO` must emit `0x155`, `underflow=0`, `overflow=0`, `rd_p=1`, `wr_p=3`, `count=2`, MSB first. Memory is unchanged afterwards (verify via functional reads after reloading the pointers by scan).
- Assert `reset` mid-scan and mid-write burst: all outputs return to their reset values immediately, without waiting for a clock.
